// File: rtl/mem_pkg.sv
// Shared data-memory access types: size encoding, buffered store entry,
// and the byte-count helper used for word-span calculations.
package mem_pkg;

    localparam int MEM_SIZE_LOG2 = 13;

    typedef enum logic [1:0] {
        MSIZE_BYTE = 2'b00,
        MSIZE_HALF = 2'b01,
        MSIZE_WORD = 2'b10
    } mem_size_t;

    typedef struct packed {
        logic [MEM_SIZE_LOG2-1:0] addr;
        mem_size_t                size;
        logic [31:0]              wdata;
    } sb_entry_t;

    function automatic logic [2:0] size_bytes(input mem_size_t s);
        case (s)
            MSIZE_BYTE: return 3'd1;
            MSIZE_HALF: return 3'd2;
            default:    return 3'd4;
        endcase
    endfunction

    // Encoding 2'b11 is accepted on the request side and behaves as a word.
    function automatic mem_size_t norm_size(input logic [1:0] s);
        return (s == 2'b11) ? MSIZE_WORD : mem_size_t'(s);
    endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// sb_fifo: DEPTH-entry circular store queue with per-entry valid bits so the
// parent can scan every occupied slot for load/store overlap.
module sb_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  sb_entry_t                push_entry_i,
    input  logic                     pop_i,
    output sb_entry_t                head_o,
    output sb_entry_t                entries_o [DEPTH],
    output logic [DEPTH-1:0]         valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    sb_entry_t        mem_q [DEPTH];

    // Callers only push below DEPTH and only pop when non-empty.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        if (pop_i) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (push_i) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end
        count_d = count_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[tail_q] <= push_entry_i;
        end
    end

    assign head_o    = mem_q[head_q];
    assign entries_o = mem_q;
    assign valid_o   = valid_q;
    assign count_o   = count_q;

endmodule

// File: rtl/store_buffer.sv
// Store buffer in front of a single-port data memory: loads take the port at once,
// buffered stores drain when it is free. Optional fence port: STORE_BUFFER_FENCE_EN.
module store_buffer
    import mem_pkg::*;
#(
    parameter int SIZE_LOG2 = MEM_SIZE_LOG2,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [1:0]             req_size,
    input  logic                   req_signed,
    input  logic [SIZE_LOG2-1:0]   req_addr,
    input  logic [31:0]            req_wdata,
    output logic                   mem_we,
    output logic [1:0]             mem_size,
    output logic                   mem_signed,
    output logic [SIZE_LOG2-1:0]   mem_a,
    output logic [31:0]            mem_wd,
    output logic                   load_valid,
    output logic [$clog2(DEPTH):0] sb_count
`ifdef STORE_BUFFER_FENCE_EN
    ,
    input  logic                   fence,
    output logic                   fence_done
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // End word index of an access; wraps with the memory's address space.
    function automatic logic [SIZE_LOG2-3:0] word_end(input logic [SIZE_LOG2-1:0] a,
                                                      input mem_size_t s);
        logic [SIZE_LOG2-1:0] last;
        last = a + SIZE_LOG2'(size_bytes(s)) - SIZE_LOG2'(1);
        return last[SIZE_LOG2-1:2];
    endfunction

    sb_entry_t            head, push_entry;
    sb_entry_t            entries [DEPTH];
    logic [DEPTH-1:0]     valid;
    logic [CW-1:0]        count;
    mem_size_t            req_sz;
    logic [SIZE_LOG2-3:0] ld_ws, ld_we, e_ws, e_we;
    logic                 hazard, block, load_acc, store_acc, drain;
    logic                 load_valid_q;
    logic [SIZE_LOG2-1:0] last_a_q;
    logic [1:0]           last_size_q;
    logic                 last_signed_q;
    logic [31:0]          last_wd_q;

    assign req_sz     = norm_size(req_size);
    assign ld_ws      = req_addr[SIZE_LOG2-1:2];
    assign ld_we      = word_end(req_addr, req_sz);
    assign push_entry = '{addr: req_addr, size: req_sz, wdata: req_wdata};

    always_comb begin
        hazard = 1'b0;
        e_ws   = '0;
        e_we   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            e_ws = entries[i].addr[SIZE_LOG2-1:2];
            e_we = word_end(entries[i].addr, entries[i].size);
            if (valid[i] && (ld_ws == e_ws || ld_ws == e_we || ld_we == e_ws || ld_we == e_we)) begin
                hazard = 1'b1;
            end
        end
    end

`ifdef STORE_BUFFER_FENCE_EN
    assign block      = fence;
    assign fence_done = (count == '0);
`else
    assign block      = 1'b0;
`endif

    assign req_ready = !block && (req_we ? (count < FULL) : !hazard);
    assign load_acc  = req_valid && !req_we && req_ready;
    assign store_acc = req_valid && req_we && req_ready;
    assign drain     = !load_acc && (count != '0);

    // Port mux: load first, then head drain, otherwise hold the last values.
    always_comb begin
        mem_we     = 1'b0;
        mem_a      = last_a_q;
        mem_size   = last_size_q;
        mem_signed = last_signed_q;
        mem_wd     = last_wd_q;
        if (load_acc) begin
            mem_a      = req_addr;
            mem_size   = req_sz;
            mem_signed = req_signed;
        end else if (drain) begin
            mem_we     = 1'b1;
            mem_a      = head.addr;
            mem_size   = head.size;
            mem_signed = 1'b0;
            mem_wd     = head.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_valid_q <= 1'b0;
        end else begin
            load_valid_q <= load_acc;
        end
    end

    always_ff @(posedge clk) begin
        last_a_q      <= mem_a;
        last_size_q   <= mem_size;
        last_signed_q <= mem_signed;
        last_wd_q     <= mem_wd;
    end

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (store_acc),
        .push_entry_i (push_entry),
        .pop_i        (drain),
        .head_o       (head),
        .entries_o    (entries),
        .valid_o      (valid),
        .count_o      (count)
    );

    assign load_valid = load_valid_q;
    assign sb_count   = count;

endmodule
